seg7_scan_decoder: RTL and testbench
====================================

Name: seg7_scan_decoder

Overview:
- Inverse of the hex-to-seven-segment path. Snoops a multiplexed seven-segment display bus (one-hot active-low anodes plus shared segment lines) and reconstructs the hex word being shown.
- Each digit is debounced per anode dwell and decoded back to a nibble. When every digit has been seen, the frame is presented on a valid/ready output.
- Used for loopback self-check of the display driver and for capturing external scanned displays.

Parameters:
- NUM_DIGITS, 8, number of multiplexed digits (anode width); frame is 4*NUM_DIGITS bits.
- STABLE_CYCLES, 16, consecutive cycles anode and segments must be unchanged before a digit is captured; legal range 1..65535.

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  reset, asynchronous assert, active-low.
- an_in  input  NUM_DIGITS  anode selects, active-low; exactly one low selects a digit.
- seg_in  input  7  segments, active-high; bit0=a, bit1=b, ... bit6=g.
- value_out  output  4*NUM_DIGITS  decoded frame; digit i occupies bits [4i+3:4i].
- blank_out  output  NUM_DIGITS  digit i captured as all-off (0x00).
- err_out  output  1  at least one digit in the frame had an unrecognised pattern.
- valid_out  output  1  frame available.
- ready_in  input  1  consumer accepts the frame.
- overrun_out  output  1  sticky flag: a completed frame was dropped.

Behaviour:
- Reset: all outputs 0. Accumulator, seen-mask, stability counter and capture flag are cleared. State = COLLECT.
- Decode table (seg_in hex -> nibble): 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7, 7F->8, 6F->9, 77->A, 7C->B, 39->C, 5E->D, 79->E, 71->F.
  - 00 -> nibble 0 with the blank bit set.
  - Any other pattern -> nibble 0 with the digit error bit set.
- Stability tracking:
  - an_in and seg_in are registered once (a 1-cycle sample stage).
  - If the sample equals the previous sample, the counter increments and saturates at STABLE_CYCLES. Otherwise the counter resets to 1 and the capture flag clears.
- Capture:
  - Occurs on the cycle the counter first reaches STABLE_CYCLES, only if the sampled an_in is one-hot-low and the capture flag is clear.
  - Writes the nibble, blank bit and error bit into slot i. Sets seen[i] and the capture flag.
  - Re-capturing an already-seen digit overwrites its slot.
- Invalid anode (none low, or more than one low): no capture; the counter still runs.
- Frame completion: on the cycle after seen becomes all-ones, the accumulator is copied to the output registers. err_out is the OR of the per-digit error bits. seen clears and valid_out rises.
- Latency: last digit stable at cycle t -> capture at t+STABLE_CYCLES+1 (includes the sample stage) -> valid_out at the next cycle.
- State machine:
  - COLLECT: valid_out=0. Frame completion -> PRESENT.
  - PRESENT: valid_out=1 and outputs held stable. Collection continues in the background.
  - PRESENT, ready_in=1, no new frame completing -> COLLECT next cycle.
  - PRESENT, ready_in=1 and a new frame completing in the same cycle -> load the new frame, stay in PRESENT, no overrun.
  - PRESENT, ready_in=0 and a new frame completing -> new frame dropped, overrun_out set; it clears only on reset.
- valid_out never deasserts without ready_in, except on reset.
- Reset mid-frame: the partial frame is discarded and nothing is emitted.

Optional Feature:
- Macro SEG7_DP_EN.
- Defined: adds input dp_in (1, decimal point, active-high) and output dp_out (NUM_DIGITS). dp_in joins the stability compare and is captured per digit alongside the nibble.
- Undefined: no dp ports; behaviour otherwise identical.

Decomposition:
- Package seg7_pkg: the 16 segment-pattern constants (bit0=a ordering), SEG_BLANK, a seg_t 7-bit typedef, and a struct {nibble, blank, err} for decoded results.
- Sub-module seg7_pattern_decode: purely combinational 7-bit pattern -> struct lookup, instantiated once on the sampled segments.

Test Plan:
- Scan digits 0..7 showing 1,2,3,4,5,6,7,8 (patterns 06,5B,4F,66,6D,7D,07,7F), dwell 32 cycles each, ready_in=1 -> value_out=32'h87654321, err_out=0, one-cycle valid_out.
- Dwell of STABLE_CYCLES-1 on digit 3 with 5E, then digits 0..7 scanned fully with digit 3 showing 71 -> no capture from the short dwell; frame nibble 3 = F.
- Digit 5 shows 0x55 -> nibble 0 and err_out=1. Digit 7 shows 0x00 -> blank_out[7]=1, err_out unaffected.
- Two complete frames with ready_in=0 throughout -> first frame held on value_out, overrun_out=1. Then ready_in=1 -> one handshake, back to COLLECT.
- an_in=8'h00 and 8'hFF held for 100 cycles -> no capture, seen unchanged. Pulse rst_n_in low during a half-complete frame -> all outputs 0 immediately, no frame afterwards until a full rescan.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan decoder.
// Segment bit ordering: bit0=a, bit1=b, ... bit6=g (active-high).
package seg7_pkg;

    typedef logic [6:0] seg_t;

    // Result of decoding one segment pattern back to a hex digit.
    typedef struct packed {
        logic [3:0] nibble;
        logic       blank;
        logic       err;
    } seg_dec_t;

    // Output frame handshake state.
    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_PRESENT = 1'b1
    } frame_state_t;

    localparam seg_t SEG_0     = 7'h3F;
    localparam seg_t SEG_1     = 7'h06;
    localparam seg_t SEG_2     = 7'h5B;
    localparam seg_t SEG_3     = 7'h4F;
    localparam seg_t SEG_4     = 7'h66;
    localparam seg_t SEG_5     = 7'h6D;
    localparam seg_t SEG_6     = 7'h7D;
    localparam seg_t SEG_7     = 7'h07;
    localparam seg_t SEG_8     = 7'h7F;
    localparam seg_t SEG_9     = 7'h6F;
    localparam seg_t SEG_A     = 7'h77;
    localparam seg_t SEG_B     = 7'h7C;
    localparam seg_t SEG_C     = 7'h39;
    localparam seg_t SEG_D     = 7'h5E;
    localparam seg_t SEG_E     = 7'h79;
    localparam seg_t SEG_F     = 7'h71;
    localparam seg_t SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational lookup: 7-bit segment pattern -> nibble, blank flag, error flag.
// Unrecognised patterns decode to nibble 0 with err set; all-off decodes to
// nibble 0 with blank set.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       blank,
    output logic       err
);

    // Reverse of the hex-to-segment table.
    always_comb begin
        nibble = 4'h0;
        blank  = 1'b0;
        err    = 1'b0;
        case (seg)
            SEG_0:     nibble = 4'h0;
            SEG_1:     nibble = 4'h1;
            SEG_2:     nibble = 4'h2;
            SEG_3:     nibble = 4'h3;
            SEG_4:     nibble = 4'h4;
            SEG_5:     nibble = 4'h5;
            SEG_6:     nibble = 4'h6;
            SEG_7:     nibble = 4'h7;
            SEG_8:     nibble = 4'h8;
            SEG_9:     nibble = 4'h9;
            SEG_A:     nibble = 4'hA;
            SEG_B:     nibble = 4'hB;
            SEG_C:     nibble = 4'hC;
            SEG_D:     nibble = 4'hD;
            SEG_E:     nibble = 4'hE;
            SEG_F:     nibble = 4'hF;
            SEG_BLANK: blank  = 1'b1;
            default:   err    = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Snoops a multiplexed seven-segment bus (active-low one-hot anodes, shared
// active-high segments), debounces each digit dwell, decodes it back to a
// nibble and presents the completed frame on a valid/ready interface.
// Optional feature macro: SEG7_DP_EN adds dp_in / dp_out (decimal points).
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 8,
    parameter int STABLE_CYCLES = 16
)
(
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic [NUM_DIGITS-1:0]   an_in,
    input  logic [6:0]              seg_in,
`ifdef SEG7_DP_EN
    input  logic                    dp_in,
    output logic [NUM_DIGITS-1:0]   dp_out,
`endif
    output logic [4*NUM_DIGITS-1:0] value_out,
    output logic [NUM_DIGITS-1:0]   blank_out,
    output logic                    err_out,
    output logic                    valid_out,
    input  logic                    ready_in,
    output logic                    overrun_out
);

    localparam logic [15:0]           STABLE_MAX = 16'(STABLE_CYCLES);
    localparam logic [NUM_DIGITS-1:0] DIGIT_ONE  = NUM_DIGITS'(1);

    logic                    dp_raw;
    logic [NUM_DIGITS-1:0]   an_s_reg;
    seg_t                    seg_s_reg;
    logic                    dp_s_reg;
    logic [15:0]             cnt_reg, cnt_next;
    logic                    cap_reg, cap_next;
    logic                    same;
    logic [NUM_DIGITS-1:0]   an_low;
    logic                    an_onehot;
    logic                    capture;
    seg_dec_t                dec;

    logic [3:0]              nib_acc_reg [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   blank_acc_reg;
    logic [NUM_DIGITS-1:0]   err_acc_reg;
    logic [NUM_DIGITS-1:0]   seen_reg;
    logic [4*NUM_DIGITS-1:0] acc_value;
    logic                    frame_done;

    frame_state_t            state_reg, state_next;
    logic                    load_frame;
    logic                    overrun_set;
    logic [4*NUM_DIGITS-1:0] value_reg;
    logic [NUM_DIGITS-1:0]   blank_reg;
    logic                    err_reg;
    logic                    overrun_reg;

`ifdef SEG7_DP_EN
    logic [NUM_DIGITS-1:0]   dp_acc_reg;
    logic [NUM_DIGITS-1:0]   dp_out_reg;
    assign dp_raw = dp_in;
    assign dp_out = dp_out_reg;
`else
    assign dp_raw = 1'b0;
`endif

    // Incoming bus equal to the held sample means the sample has not moved;
    // the counter therefore tracks how many cycles the sample has been stable.
    assign same = (an_in == an_s_reg) && (seg_in == seg_s_reg) && (dp_raw == dp_s_reg);

    assign an_low    = ~an_s_reg;
    assign an_onehot = (an_low != '0) && ((an_low & (an_low - DIGIT_ONE)) == '0);
    assign capture   = (cnt_reg == STABLE_MAX) && !cap_reg && an_onehot;
    assign frame_done = &seen_reg;

    // Sample stage, stability counter and per-dwell capture flag.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            an_s_reg  <= '0;
            seg_s_reg <= '0;
            dp_s_reg  <= 1'b0;
            cnt_reg   <= '0;
            cap_reg   <= 1'b0;
        end else begin
            an_s_reg  <= an_in;
            seg_s_reg <= seg_in;
            dp_s_reg  <= dp_raw;
            cnt_reg   <= cnt_next;
            cap_reg   <= cap_next;
        end
    end

    // Saturating counter; any change restarts the dwell and re-arms capture.
    always_comb begin
        cnt_next = 16'd1;
        cap_next = 1'b0;
        if (same) begin
            cnt_next = (cnt_reg == STABLE_MAX) ? STABLE_MAX : cnt_reg + 16'd1;
            cap_next = cap_reg | capture;
        end
    end

    seg7_pattern_decode u_decode (
        .seg    (seg_s_reg),
        .nibble (dec.nibble),
        .blank  (dec.blank),
        .err    (dec.err)
    );

    // One accumulator slot per digit; a capture beats the frame-complete
    // clear so a digit landing on that cycle starts the next frame.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_slot
            assign acc_value[4*gi +: 4] = nib_acc_reg[gi];

            // Slot write on capture of this anode.
            always_ff @(posedge clk_in or negedge rst_n_in) begin
                if (!rst_n_in) begin
                    nib_acc_reg[gi]   <= 4'h0;
                    blank_acc_reg[gi] <= 1'b0;
                    err_acc_reg[gi]   <= 1'b0;
                    seen_reg[gi]      <= 1'b0;
`ifdef SEG7_DP_EN
                    dp_acc_reg[gi]    <= 1'b0;
`endif
                end else if (capture && an_low[gi]) begin
                    nib_acc_reg[gi]   <= dec.nibble;
                    blank_acc_reg[gi] <= dec.blank;
                    err_acc_reg[gi]   <= dec.err;
                    seen_reg[gi]      <= 1'b1;
`ifdef SEG7_DP_EN
                    dp_acc_reg[gi]    <= dp_s_reg;
`endif
                end else if (frame_done) begin
                    seen_reg[gi]      <= 1'b0;
                end
            end
        end
    endgenerate

    // Frame state register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state_reg <= ST_COLLECT;
        else           state_reg <= state_next;
    end

    // Handshake: load on completion unless a presented frame is still unaccepted.
    always_comb begin
        state_next  = state_reg;
        load_frame  = 1'b0;
        overrun_set = 1'b0;
        case (state_reg)
            ST_COLLECT: begin
                if (frame_done) begin
                    load_frame = 1'b1;
                    state_next = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (ready_in) begin
                    if (frame_done) load_frame = 1'b1;
                    else            state_next = ST_COLLECT;
                end else if (frame_done) begin
                    overrun_set = 1'b1;
                end
            end
            default: state_next = ST_COLLECT;
        endcase
    end

    // Output frame registers and sticky overrun flag.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            value_reg   <= '0;
            blank_reg   <= '0;
            err_reg     <= 1'b0;
            overrun_reg <= 1'b0;
`ifdef SEG7_DP_EN
            dp_out_reg  <= '0;
`endif
        end else begin
            if (load_frame) begin
                value_reg  <= acc_value;
                blank_reg  <= blank_acc_reg;
                err_reg    <= |err_acc_reg;
`ifdef SEG7_DP_EN
                dp_out_reg <= dp_acc_reg;
`endif
            end
            if (overrun_set) overrun_reg <= 1'b1;
        end
    end

    assign value_out   = value_reg;
    assign blank_out   = blank_reg;
    assign err_out     = err_reg;
    assign overrun_out = overrun_reg;
    assign valid_out   = (state_reg == ST_PRESENT);

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder (default parameters, 8 digits, 16-cycle dwell).
module tb_seg7_scan_decoder;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic [7:0]  an_in;
    logic [6:0]  seg_in;
    logic [31:0] value_out;
    logic [7:0]  blank_out;
    logic        err_out;
    logic        valid_out;
    logic        ready_in;
    logic        overrun_out;
`ifdef SEG7_DP_EN
    logic        dp_in = 1'b0;
    logic [7:0]  dp_out;
`endif

    int tests_run    = 0;
    int tests_failed = 0;
    int valid_cycles = 0;

    logic [31:0] frame_q [$];
    logic        err_q   [$];
    logic [7:0]  blank_q [$];
    logic [6:0]  cur     [8];

    always #5 clk_in = ~clk_in;

    seg7_scan_decoder #(.NUM_DIGITS(8), .STABLE_CYCLES(16)) dut (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .an_in       (an_in),
        .seg_in      (seg_in),
`ifdef SEG7_DP_EN
        .dp_in       (dp_in),
        .dp_out      (dp_out),
`endif
        .value_out   (value_out),
        .blank_out   (blank_out),
        .err_out     (err_out),
        .valid_out   (valid_out),
        .ready_in    (ready_in),
        .overrun_out (overrun_out)
    );

    // Record every accepted frame, one line per handshake.
    always @(negedge clk_in) begin
        if (valid_out) valid_cycles++;
        if (valid_out && ready_in) begin
            frame_q.push_back(value_out);
            err_q.push_back(err_out);
            blank_q.push_back(blank_out);
            $display("[TB] frame value=%h err=%0b blank=%h overrun=%0b", value_out, err_out, blank_out, overrun_out);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic show_digit(input int idx, input logic [6:0] pat, input int dwell);
        logic [7:0] sel;
        sel    = 8'h01 << idx;
        an_in  = ~sel;
        seg_in = pat;
        tick(dwell);
    endtask

    task automatic scan(input int lo, input int hi, input int dwell);
        for (int i = lo; i <= hi; i++) show_digit(i, cur[i], dwell);
    endtask

    task automatic idle(input int n);
        an_in  = 8'hFF;
        seg_in = 7'h00;
        tick(n);
    endtask

    task automatic expect_frame(input string tag, input logic [31:0] exp_val,
                                input logic exp_err, input logic [7:0] exp_blank);
        check({tag, "_count"}, 32'(frame_q.size()), 32'd1);
        if (frame_q.size() > 0) begin
            check({tag, "_value"}, frame_q.pop_front(), exp_val);
            check({tag, "_err"},   32'(err_q.pop_front()), 32'(exp_err));
            check({tag, "_blank"}, 32'(blank_q.pop_front()), 32'(exp_blank));
        end
    endtask

    initial begin
        int v0;
        rst_n_in = 1'b0;
        ready_in = 1'b1;
        an_in    = 8'hFF;
        seg_in   = 7'h00;
        tick(3);
        check("rst_value",   value_out, 32'h0);
        check("rst_valid",   32'(valid_out), 32'd0);
        check("rst_blank",   32'(blank_out), 32'd0);
        check("rst_err",     32'(err_out), 32'd0);
        check("rst_overrun", 32'(overrun_out), 32'd0);
        rst_n_in = 1'b1;
        tick(2);

        // Basic frame 1..8, single-cycle valid with ready held high.
        cur = '{7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F};
        v0 = valid_cycles;
        scan(0, 7, 32);
        idle(4);
        expect_frame("basic", 32'h87654321, 1'b0, 8'h00);
        check("basic_valid_len", 32'(valid_cycles - v0), 32'd1);

        // Short dwell (15) of D on digit 3 after F was captured must not overwrite.
        cur[3] = 7'h71;
        scan(0, 3, 32);
        show_digit(3, 7'h5E, 15);
        scan(4, 7, 32);
        idle(4);
        expect_frame("short_dwell", 32'h8765F321, 1'b0, 8'h00);

        // Dwell of exactly 16 captures every digit.
        cur = '{7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71, 7'h3F};
        scan(0, 7, 16);
        idle(4);
        expect_frame("dwell16", 32'h0FEDCBA9, 1'b0, 8'h00);

        // Dwell of 15 everywhere produces no frame.
        scan(0, 7, 15);
        idle(4);
        check("dwell15_none", 32'(frame_q.size()), 32'd0);
        check("dwell15_valid", 32'(valid_out), 32'd0);

        // Error digit 5 and blank digit 7.
        cur = '{7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h55, 7'h07, 7'h00};
        scan(0, 7, 32);
        idle(4);
        expect_frame("err_blank", 32'h07054321, 1'b1, 8'h80);

        // Back-pressure: two frames with ready low, second is dropped.
        ready_in = 1'b0;
        cur = '{7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F};
        scan(0, 7, 32);
        idle(4);
        check("bp_valid1",   32'(valid_out), 32'd1);
        check("bp_value1",   value_out, 32'h87654321);
        check("bp_overrun1", 32'(overrun_out), 32'd0);
        cur = '{7'h6F, 7'h6F, 7'h6F, 7'h6F, 7'h6F, 7'h6F, 7'h6F, 7'h6F};
        scan(0, 7, 32);
        idle(4);
        check("bp_valid2",   32'(valid_out), 32'd1);
        check("bp_value2",   value_out, 32'h87654321);
        check("bp_overrun2", 32'(overrun_out), 32'd1);
        check("bp_no_hs",    32'(frame_q.size()), 32'd0);
        ready_in = 1'b1;
        tick(1);
        check("bp_valid_drop", 32'(valid_out), 32'd0);
        expect_frame("bp_hs", 32'h87654321, 1'b0, 8'h00);
        check("bp_overrun_sticky", 32'(overrun_out), 32'd1);

        // Invalid anodes held long do not disturb the half-collected frame.
        cur = '{7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F};
        scan(0, 3, 32);
        an_in = 8'h00; seg_in = 7'h79; tick(100);
        an_in = 8'hFF; seg_in = 7'h79; tick(100);
        check("inv_none",  32'(frame_q.size()), 32'd0);
        check("inv_valid", 32'(valid_out), 32'd0);
        scan(4, 7, 32);
        idle(4);
        expect_frame("inv_anode", 32'h87654321, 1'b0, 8'h00);

        // Reset mid-frame clears outputs at once and discards the partial frame.
        cur = '{7'h4F, 7'h4F, 7'h4F, 7'h4F, 7'h66, 7'h66, 7'h66, 7'h66};
        scan(0, 3, 32);
        rst_n_in = 1'b0;
        #1;
        check("mid_rst_value",   value_out, 32'h0);
        check("mid_rst_overrun", 32'(overrun_out), 32'd0);
        check("mid_rst_valid",   32'(valid_out), 32'd0);
        tick(2);
        rst_n_in = 1'b1;
        scan(4, 7, 32);
        idle(20);
        check("mid_rst_none",  32'(frame_q.size()), 32'd0);
        check("mid_rst_valid2", 32'(valid_out), 32'd0);
        scan(0, 7, 32);
        idle(4);
        expect_frame("rescan", 32'h44443333, 1'b0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
